dr_rmw_unit: RTL and testbench
==============================

# dr_rmw_unit

Parametrised data register (DR) with load, increment, decrement and clear, plus a built-in read-modify-write sequencer for ISZ/DSZ-style instructions. It sits on the datapath between memory and the ALU. It replaces the purely level-driven DR with a clocked register and a memory handshake. The controller starts one command and receives a single done/skip result when the memory location has been updated.

## Interface
- WIDTH, 16, data register and memory data width
- ADDR_W, 12, memory address width

- clk  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- CLR_GLOBAL  in  1  synchronous global clear; highest priority; aborts any sequence
- in_DR  in  WIDTH  parallel load data
- LD, INR, DCR, CLR  in  1 each  direct register commands; sampled only in IDLE
- start  in  1  begin read-modify-write; sampled only in IDLE
- op  in  1  0 = increment (ISZ), 1 = decrement (DSZ); captured with start
- addr  in  ADDR_W  target address; captured with start
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  captured address
- mem_wdata  out  WIDTH  equals out_DR
- mem_rdata  in  WIDTH  read data; valid with mem_ack
- mem_ack  in  1  one-cycle acknowledge of the current request
- out_DR  out  WIDTH  register contents
- Zero_DR  out  1  out_DR == 0 (combinational)
- Neg_DR  out  1  out_DR[WIDTH-1]
- Ovf_DR  out  1  sticky wrap flag
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- skip  out  1  valid with done; 1 when the written result is zero

## Operation
- Reset (async, RST_N=0) state:
  - out_DR=0, Zero_DR=1, Neg_DR=0, Ovf_DR=0
  - state IDLE
  - mem_req=0, mem_we=0, mem_addr=0
  - busy=0, done=0, skip=0
- IDLE command priority per edge: CLR_GLOBAL > start > CLR > LD > INR > DCR.
  - CLR: DR<=0, Ovf<=0.
  - LD: DR<=in_DR, Ovf<=0.
  - INR: DR<=DR+1 modulo 2^WIDTH. Ovf<=1 if DR was all-ones.
  - DCR: DR<=DR-1 modulo 2^WIDTH. Ovf<=1 if DR was 0.
  - Otherwise Ovf holds.
- start in IDLE: capture op and addr, go to RD. LD/INR/DCR/CLR in the same cycle are ignored.
- FSM states:
  - IDLE.
  - RD: mem_req=1, mem_we=0. Hold until mem_ack. On ack: DR<=mem_rdata, Ovf<=0, go to MOD.
  - MOD: apply INR (op=0) or DCR (op=1) with the same wrap and Ovf rules, go to WR.
  - WR: mem_req=1, mem_we=1, mem_wdata=out_DR. Hold until mem_ack, then go to DONE.
  - DONE: done=1, skip=Zero_DR, go to IDLE.
- mem_ack outside RD/WR is ignored.
- While busy: LD/INR/DCR/CLR/start are ignored; no queuing.
- CLR_GLOBAL in any state: next edge gives DR=0, Ovf=0, state IDLE, mem_req=0. No done pulse. A write in flight is abandoned.
- Async reset mid-sequence gives the reset state immediately.
- mem_addr holds its captured value until the next start.

## Timing
- All outputs are registered or state-decoded, except Zero_DR, Neg_DR and mem_wdata, which decode out_DR.
- Direct commands take effect at the sampling edge; flags follow in the same cycle.
- RMW with zero-wait memory (ack in first request cycle):
  - start at edge 0.
  - RD during cycle 1; ack at edge 1.
  - MOD cycle 2.
  - WR cycle 3; ack at edge 3.
  - DONE cycle 4 (done=1).
  - IDLE from edge 4.
  - Minimum start-to-done latency is 4 cycles. Each wait cycle in RD or WR adds one.
- start is accepted again at the edge ending DONE+1, i.e. when busy=0 is observed.
- mem_req stays high continuously from RD entry to ack. It drops for exactly the MOD cycle between read and write.

## Test plan
- Reset and direct commands:
  - Assert RST_N=0 mid-cycle: all outputs go to reset values at once.
  - LD 0x7FFF then INR: DR=0x8000, Neg=1, Ovf=0.
  - LD 0xFFFF then INR: DR=0, Zero=1, Ovf=1.
  - CLR: Ovf=0.
- DCR at 0: DR=0xFFFF, Ovf=1. Then LD and INR asserted together: LD wins, DR=in_DR.
- ISZ with zero-wait memory: rdata 0xFFFF at addr 0x123, op=0.
  - Read then write to 0x123 with wdata=0x0000.
  - done at cycle 4 with skip=1, Ovf=1.
- DSZ with ack delayed 3 cycles on both phases: rdata 0x0005.
  - wdata=0x0004, skip=0.
  - done at cycle 10; mem_req low only in MOD.
- CLR_GLOBAL asserted during WR wait: next cycle IDLE, mem_req=0, DR=0, no done.
  - A following start proceeds normally.
- start, LD and ack pulses while busy: no effect on DR, state or result.
  - Stray ack in MOD does not advance the FSM.

Source files
------------

// File: rtl/dr_rmw_unit.sv
// Clocked data register with load/inc/dec/clear and a read-modify-write sequencer
// for ISZ/DSZ-style instructions: read memory, inc/dec in DR, write back, report skip.
module dr_rmw_unit #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              CLR_GLOBAL,
  input  logic [WIDTH-1:0]  in_DR,
  input  logic              LD,
  input  logic              INR,
  input  logic              DCR,
  input  logic              CLR,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [WIDTH-1:0]  out_DR,
  output logic              Zero_DR,
  output logic              Neg_DR,
  output logic              Ovf_DR,
  output logic              busy,
  output logic              done,
  output logic              skip
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MOD,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    dr_reg, dr_next;
  logic                ovf_reg, ovf_next;
  logic                op_reg, op_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;

  logic [WIDTH-1:0]    inc_val, dec_val;
  logic                inc_wrap, dec_wrap;

  // Shared by the direct INR/DCR commands and the MOD step of the sequencer
  assign inc_val  = dr_reg + 1'b1;
  assign dec_val  = dr_reg - 1'b1;
  assign inc_wrap = (dr_reg == ALL_ONES);
  assign dec_wrap = (dr_reg == ALL_ZERO);

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= S_IDLE;
      dr_reg    <= '0;
      ovf_reg   <= 1'b0;
      op_reg    <= 1'b0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      dr_reg    <= dr_next;
      ovf_reg   <= ovf_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dr_next    = dr_reg;
    ovf_next   = ovf_reg;
    op_next    = op_reg;
    addr_next  = addr_reg;

    if (CLR_GLOBAL) begin
      // Abandons any sequence, including a write still waiting for ack
      state_next = S_IDLE;
      dr_next    = '0;
      ovf_next   = 1'b0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_next    = op;
            addr_next  = addr;
            state_next = S_RD;
          end else if (CLR) begin
            dr_next  = '0;
            ovf_next = 1'b0;
          end else if (LD) begin
            dr_next  = in_DR;
            ovf_next = 1'b0;
          end else if (INR) begin
            dr_next = inc_val;
            if (inc_wrap) ovf_next = 1'b1;
          end else if (DCR) begin
            dr_next = dec_val;
            if (dec_wrap) ovf_next = 1'b1;
          end
        end
        S_RD: begin
          if (mem_ack) begin
            dr_next    = mem_rdata;
            ovf_next   = 1'b0;
            state_next = S_MOD;
          end
        end
        S_MOD: begin
          if (!op_reg) begin
            dr_next = inc_val;
            if (inc_wrap) ovf_next = 1'b1;
          end else begin
            dr_next = dec_val;
            if (dec_wrap) ovf_next = 1'b1;
          end
          state_next = S_WR;
        end
        S_WR: begin
          if (mem_ack) state_next = S_DONE;
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = (state_reg == S_RD) || (state_reg == S_WR);
  assign mem_we    = (state_reg == S_WR);
  assign mem_addr  = addr_reg;
  assign mem_wdata = dr_reg;

  assign out_DR    = dr_reg;
  assign Zero_DR   = (dr_reg == ALL_ZERO);
  assign Neg_DR    = dr_reg[WIDTH-1];
  assign Ovf_DR    = ovf_reg;

  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  // DR still holds the written value during DONE
  assign skip      = (state_reg == S_DONE) && Zero_DR;

endmodule

// File: tb/tb_dr_rmw_unit.sv
// Directed plus randomized bench for dr_rmw_unit: a behavioural model of DR/Ovf and
// a memory array predicts every read-modify-write result and its latency.
module tb_dr_rmw_unit;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        CLR_GLOBAL;
  logic [15:0] in_DR;
  logic        LD, INR, DCR, CLR;
  logic        start, op;
  logic [11:0] addr;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [15:0] out_DR;
  logic        Zero_DR, Neg_DR, Ovf_DR, busy, done, skip;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural reference: register value, sticky flag and memory contents
  logic [15:0] mdr;
  logic        movf;
  logic [15:0] mem_model [4096];

  int   rd_delay = 0;
  int   wr_delay = 0;
  logic resp_ack;
  logic stray_ack;
  int   resp_cnt;

  int          wr_cnt = 0;
  logic [11:0] last_waddr = '0;
  logic [15:0] last_wdata = '0;

  dr_rmw_unit #(.WIDTH(16), .ADDR_W(12)) dut (
    .clk(clk), .RST_N(RST_N), .CLR_GLOBAL(CLR_GLOBAL), .in_DR(in_DR),
    .LD(LD), .INR(INR), .DCR(DCR), .CLR(CLR), .start(start), .op(op), .addr(addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .out_DR(out_DR), .Zero_DR(Zero_DR),
    .Neg_DR(Neg_DR), .Ovf_DR(Ovf_DR), .busy(busy), .done(done), .skip(skip)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_model[mem_addr];
  assign mem_ack   = resp_ack | stray_ack;

  // Memory responder: acknowledges after the configured number of wait cycles
  initial begin
    resp_ack = 1'b0;
    resp_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (resp_cnt >= (mem_we ? wr_delay : rd_delay)) begin
          resp_ack = 1'b1;
          resp_cnt = 0;
        end else begin
          resp_ack = 1'b0;
          resp_cnt++;
        end
      end else begin
        resp_ack = 1'b0;
        resp_cnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (mem_req === 1'b1 && mem_we === 1'b1 && mem_ack === 1'b1) begin
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= mem_addr;
      last_wdata <= mem_wdata;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_dr"},    32'(out_DR),   32'(0));
    chk({tag, "_zero"},  32'(Zero_DR),  32'(1));
    chk({tag, "_neg"},   32'(Neg_DR),   32'(0));
    chk({tag, "_ovf"},   32'(Ovf_DR),   32'(0));
    chk({tag, "_req"},   32'(mem_req),  32'(0));
    chk({tag, "_we"},    32'(mem_we),   32'(0));
    chk({tag, "_maddr"}, 32'(mem_addr), 32'(0));
    chk({tag, "_busy"},  32'(busy),     32'(0));
    chk({tag, "_done"},  32'(done),     32'(0));
    chk({tag, "_skip"},  32'(skip),     32'(0));
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_dr"},   32'(out_DR),  32'(mdr));
    chk({tag, "_zero"}, 32'(Zero_DR), 32'(mdr == 16'd0));
    chk({tag, "_neg"},  32'(Neg_DR),  32'(mdr >= 16'h8000));
    chk({tag, "_ovf"},  32'(Ovf_DR),  32'(movf));
    chk({tag, "_busy"}, 32'(busy),    32'(0));
  endtask

  // Direct command in IDLE: model applies the priority order with plain arithmetic
  task automatic do_cmd(input string tag, input logic cg, input logic ld, input logic inr,
                        input logic dcr, input logic clr, input logic [15:0] data);
    CLR_GLOBAL = cg; LD = ld; INR = inr; DCR = dcr; CLR = clr; in_DR = data;
    if (cg || clr) begin
      mdr = 16'd0; movf = 1'b0;
    end else if (ld) begin
      mdr = data; movf = 1'b0;
    end else if (inr) begin
      if (mdr == 16'hFFFF) movf = 1'b1;
      mdr = 16'((int'(mdr) + 1) % 65536);
    end else if (dcr) begin
      if (mdr == 16'h0000) movf = 1'b1;
      mdr = 16'((int'(mdr) + 65535) % 65536);
    end
    tick();
    CLR_GLOBAL = 0; LD = 0; INR = 0; DCR = 0; CLR = 0;
    check_regs(tag);
  endtask

  task automatic run_rmw(input string tag, input logic o, input logic [11:0] a,
                         input int rdd, input int wrd, input bit junk);
    int          v, c, rd_cyc, wr_cyc, gap, wcnt0;
    logic [15:0] res;
    logic        eovf;
    bit          addr_ok;
    v    = int'(mem_model[a]);
    res  = o ? 16'((v + 65535) % 65536) : 16'((v + 1) % 65536);
    eovf = o ? (v == 0) : (v == 65535);
    rd_delay = rdd;
    wr_delay = wrd;
    wcnt0    = wr_cnt;
    start = 1'b1; op = o; addr = a;
    if (junk) begin
      LD = 1'b1; INR = 1'b1; in_DR = 16'($urandom);
    end
    tick();
    start = 1'b0; LD = 1'b0; INR = 1'b0;
    op = 1'($urandom); addr = 12'($urandom);
    c = 1; rd_cyc = 0; wr_cyc = 0; gap = 0; addr_ok = 1;
    while (done !== 1'b1 && c < 80) begin
      if (mem_req && !mem_we) rd_cyc++;
      else if (mem_req && mem_we) wr_cyc++;
      else gap++;
      if (mem_req && mem_addr !== a) addr_ok = 0;
      if (junk) begin
        start = 1'($urandom); LD = 1'($urandom); INR = 1'($urandom);
        DCR = 1'($urandom); CLR = 1'($urandom);
        in_DR = 16'($urandom); addr = 12'($urandom);
        stray_ack = !mem_req;
      end
      tick();
      c++;
    end
    start = 0; LD = 0; INR = 0; DCR = 0; CLR = 0; stray_ack = 0;
    chk({tag, "_latency"}, 32'(c),      32'(4 + rdd + wrd));
    chk({tag, "_rdcyc"},   32'(rd_cyc), 32'(rdd + 1));
    chk({tag, "_wrcyc"},   32'(wr_cyc), 32'(wrd + 1));
    chk({tag, "_gap"},     32'(gap),    32'(1));
    chk({tag, "_addr"},    32'(addr_ok), 32'(1));
    chk({tag, "_skip"},    32'(skip),   32'(res == 16'd0));
    chk({tag, "_dr"},      32'(out_DR), 32'(res));
    chk({tag, "_ovf"},     32'(Ovf_DR), 32'(eovf));
    chk({tag, "_wcnt"},    32'(wr_cnt), 32'(wcnt0 + 1));
    chk({tag, "_wdata"},   32'(last_wdata), 32'(res));
    chk({tag, "_waddr"},   32'(last_waddr), 32'(a));
    mdr = res; movf = eovf; mem_model[a] = res;
    tick();
    chk({tag, "_idle"},    32'(busy), 32'(0));
    chk({tag, "_donelo"},  32'(done), 32'(0));
    chk({tag, "_hold"},    32'(out_DR), 32'(mdr));
  endtask

  initial begin
    int          k, wcnt_abort;
    logic [11:0] ra;
    logic [15:0] rv;

    for (int i = 0; i < 4096; i++) mem_model[i] = 16'($urandom);
    RST_N = 1'b0; CLR_GLOBAL = 0; in_DR = '0; LD = 0; INR = 0; DCR = 0; CLR = 0;
    start = 0; op = 0; addr = '0; stray_ack = 0;
    mdr = 16'd0; movf = 1'b0;
    tick(); tick();
    check_reset_outs("reset");
    #3 RST_N = 1'b1;
    tick();
    check_regs("post_reset");

    // Directed register commands and flag boundaries
    do_cmd("ld_7fff", 0, 1, 0, 0, 0, 16'h7FFF);
    do_cmd("inr_7fff", 0, 0, 1, 0, 0, 16'h0000);
    chk("inr_7fff_val", 32'(out_DR), 32'h8000);
    chk("inr_7fff_neg", 32'(Neg_DR), 32'(1));
    do_cmd("ld_ffff", 0, 1, 0, 0, 0, 16'hFFFF);
    do_cmd("inr_ffff", 0, 0, 1, 0, 0, 16'h0000);
    chk("inr_wrap_val", 32'(out_DR), 32'h0000);
    chk("inr_wrap_ovf", 32'(Ovf_DR), 32'(1));
    do_cmd("clr", 0, 0, 0, 0, 1, 16'h0000);
    chk("clr_ovf", 32'(Ovf_DR), 32'(0));
    do_cmd("dcr_zero", 0, 0, 0, 1, 0, 16'h0000);
    chk("dcr_wrap_val", 32'(out_DR), 32'hFFFF);
    chk("dcr_wrap_ovf", 32'(Ovf_DR), 32'(1));
    do_cmd("ld_vs_inr", 0, 1, 1, 0, 0, 16'h1234);
    chk("ld_wins", 32'(out_DR), 32'h1234);

    // Random mixes of simultaneous direct commands
    for (int i = 0; i < 40; i++) begin
      do_cmd("rnd_cmd", 1'($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
    end

    // ISZ, zero-wait memory
    mem_model[12'h123] = 16'hFFFF;
    run_rmw("isz", 1'b0, 12'h123, 0, 0, 0);
    chk("isz_mem", 32'(mem_model[12'h123]), 32'h0000);

    // DSZ, three wait cycles on both phases, with junk commands and stray acks while busy
    mem_model[12'h045] = 16'h0005;
    run_rmw("dsz", 1'b1, 12'h045, 3, 3, 1);
    chk("dsz_wdata", 32'(last_wdata), 32'h0004);

    // Asynchronous reset in the middle of a sequence
    mem_model[12'h200] = 16'h00FF;
    rd_delay = 2;
    start = 1'b1; op = 1'b0; addr = 12'h200;
    tick();
    start = 1'b0;
    tick();
    chk("rst_mid_busy", 32'(busy), 32'(1));
    #2 RST_N = 1'b0;
    #1 check_reset_outs("rst_mid");
    #2 RST_N = 1'b1;
    mdr = 16'd0; movf = 1'b0;
    tick();
    check_regs("after_rst_mid");

    // CLR_GLOBAL while a write waits for ack
    mem_model[12'h3A0] = 16'h0010;
    rd_delay = 0; wr_delay = 6;
    wcnt_abort = wr_cnt;
    start = 1'b1; op = 1'b0; addr = 12'h3A0;
    tick();
    start = 1'b0;
    k = 0;
    while (!(mem_req === 1'b1 && mem_we === 1'b1) && k < 20) begin
      tick();
      k++;
    end
    chk("abort_in_wr", 32'(mem_we), 32'(1));
    tick();
    CLR_GLOBAL = 1'b1;
    tick();
    CLR_GLOBAL = 1'b0;
    mdr = 16'd0; movf = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_req",  32'(mem_req), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    check_regs("abort");
    tick();
    chk("abort_nodone", 32'(done), 32'(0));
    chk("abort_nowrite", 32'(wr_cnt), 32'(wcnt_abort));
    run_rmw("after_abort", 1'b0, 12'h3A0, 1, 0, 0);

    // Randomized read-modify-write runs with boundary-biased memory contents
    for (int i = 0; i < 8; i++) begin
      ra = 12'($urandom);
      case ($urandom_range(0, 3))
        0: rv = 16'h0000;
        1: rv = 16'hFFFF;
        2: rv = 16'h0001;
        default: rv = 16'($urandom);
      endcase
      mem_model[ra] = rv;
      run_rmw("rnd_rmw", 1'($urandom), ra, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1);
      do_cmd("rnd_after", 0, 0, 1'($urandom), 1'($urandom), 0, 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
